// File: rtl/omp_arb_pkg.sv
// omp_arb_pkg: shared types for the OMP V-RAM arbiter.
// Holds the FSM encoding and a width helper.
package omp_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/omp_rr_pick.sv
// omp_rr_pick: combinational round-robin picker.
// Ports: req vector, start index -> onehot, idx, any.
module omp_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/omp_v_arbiter.sv
// omp_v_arbiter: round-robin share of one 1-cycle RAM port.
// Ports: req/req_we/req_addr/req_d in, gnt/rvalid/rdata out,
// ram_addr0/ce0/d0/we0 to the RAM, ram_q0 back from it.
module omp_v_arbiter
  import omp_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 7,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*AWIDTH-1:0] req_addr,
  input  logic [N_REQ*DWIDTH-1:0] req_d,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DWIDTH-1:0]       rdata,
  output logic [AWIDTH-1:0]       ram_addr0,
  output logic                    ram_ce0,
  output logic [DWIDTH-1:0]       ram_d0,
  output logic                    ram_we0,
  input  logic [DWIDTH-1:0]       ram_q0
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(BURST_MAX + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  arb_state_e       fsm_q, fsm_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;

  logic [IW-1:0]    base, start;
  logic [N_REQ-1:0] pick_oh, owner_oh, gnt_oh;
  logic [IW-1:0]    pick_idx, g_idx, sel;
  logic             pick_any, keep, others, any;

  // owner == last while in OWN, so rotation starts after it
  assign base  = (fsm_q == OWN) ? owner_q : last_q;
  assign start = (base == LAST_IDX) ? '0 : base + 1'b1;

  omp_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign others   = |(req & ~owner_oh);

  // owner is only pushed out once its burst is used up
  // and someone else is actually waiting
  assign keep = (fsm_q == OWN) && req[owner_q] &&
                !((burst_cnt_q == BMAX) && others);

  assign any    = keep | pick_any;
  assign g_idx  = keep ? owner_q : pick_idx;
  assign gnt_oh = keep ? owner_oh : pick_oh;
  assign sel    = any ? g_idx : last_q;

  assign gnt       = rst_n ? gnt_oh : '0;
  assign ram_ce0   = rst_n & any;
  assign ram_we0   = rst_n & any & req_we[g_idx];
  assign ram_addr0 = req_addr[sel*AWIDTH +: AWIDTH];
  assign ram_d0    = req_d[sel*DWIDTH +: DWIDTH];
  assign rdata     = ram_q0;
  assign rvalid    = rvalid_q;

  always_comb begin
    fsm_d       = fsm_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    rvalid_d    = '0;
    if (any) begin
      fsm_d   = OWN;
      owner_d = g_idx;
      last_d  = g_idx;
      if (fsm_q == OWN && g_idx == owner_q) begin
        burst_cnt_d = (burst_cnt_q == BMAX) ?
                      BMAX : burst_cnt_q + 1'b1;
      end else begin
        burst_cnt_d = CW'(1);
      end
      if (!req_we[g_idx]) rvalid_d = gnt_oh;
    end else begin
      fsm_d       = IDLE;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      owner_q     <= '0;
      last_q      <= LAST_IDX;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      fsm_q       <= fsm_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_omp_v_arbiter.sv
// tb_omp_v_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural arbiter model.
module tb_omp_v_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BM = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_d;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, ram_d0, ram_q0;
  logic [AW-1:0]   ram_addr0;
  logic            ram_ce0, ram_we0;

  omp_v_arbiter #(
    .N_REQ(N), .DWIDTH(DW), .AWIDTH(AW), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_d(req_d),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr0(ram_addr0), .ram_ce0(ram_ce0),
    .ram_d0(ram_d0), .ram_we0(ram_we0),
    .ram_q0(ram_q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write-first single-port RAM, 1-cycle read latency
  logic [DW-1:0] ram_mem [128];
  always @(posedge clk) begin
    if (ram_ce0) begin
      if (ram_we0) begin
        ram_mem[ram_addr0] <= ram_d0;
        ram_q0 <= ram_d0;
      end else begin
        ram_q0 <= ram_mem[ram_addr0];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp_v, $time);
    end
  endtask

  // behavioural model: run length of the current holder,
  // last winner, a shadow memory and the pending response
  int            prev_g, run_len, last_w, acc_g;
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_rd;
  bit            exp_rd_ok;
  logic [DW-1:0] mdl_mem [128];
  bit            mdl_known [128];

  task automatic model_reset();
    prev_g  = -1;
    run_len = 0;
    last_w  = N - 1;
    exp_rv  = '0;
    acc_g   = -1;
  endtask

  task automatic model_step();
    int g;
    logic [N-1:0] tmp, eg;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic w;
    g = -1;
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_ce", ram_ce0, 0);
      chk("rst_rvalid", rvalid, 0);
      acc_g = -1;
      return;
    end
    if (prev_g >= 0 && req[prev_g]) begin
      tmp = req;
      tmp[prev_g] = 1'b0;
      if (!(run_len >= BM && tmp != '0)) g = prev_g;
    end
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last_w + k) % N;
      if (g < 0 && req[j]) g = j;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", gnt, eg);
    chk("ce", ram_ce0, g >= 0);
    chk("rvalid", rvalid, exp_rv);
    if (exp_rv != '0 && exp_rd_ok) chk("rdata", rdata, exp_rd);
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      d = req_d[g*DW +: DW];
      w = req_we[g];
      chk("we0", ram_we0, w);
      chk("addr0", ram_addr0, a);
      if (w) chk("d0", ram_d0, d);
      if (w) begin
        mdl_mem[a]   = d;
        mdl_known[a] = 1'b1;
        exp_rv       = '0;
      end else begin
        exp_rv    = eg;
        exp_rd    = mdl_mem[a];
        exp_rd_ok = mdl_known[a];
      end
      run_len = (g == prev_g) ?
                ((run_len < BM) ? run_len + 1 : BM) : 1;
      prev_g = g;
      last_w = g;
    end else begin
      chk("we0_idle", ram_we0, 0);
      exp_rv  = '0;
      prev_g  = -1;
      run_len = 0;
    end
    acc_g = g;
  endtask

  task automatic drive(input logic [N-1:0] r,
                       input logic [N-1:0] w,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req    = r;
    req_we = w;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a;
      req_d[i*DW +: DW]    = d;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]  r;
    logic [N-1:0]  w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [N-1:0]  e_gnt;
    logic          e_we0;
    logic [N-1:0]  e_rv;
    bit            c_rd;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tv [15];

  initial begin
    tv[0]  = '{4'b0001, 4'b0001, 7'd5, 32'hDEADBEEF,
               4'b0001, 1'b1, 4'b0000, 1'b0, 32'h0};
    tv[1]  = '{4'b0001, 4'b0000, 7'd5, 32'h0,
               4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0};
    tv[2]  = '{4'b0000, 4'b0000, 7'd5, 32'h0,
               4'b0000, 1'b0, 4'b0001, 1'b1, 32'hDEADBEEF};
    tv[3]  = '{4'b1000, 4'b0000, 7'd1, 32'h0,
               4'b1000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tv[4]  = '{4'b0101, 4'b0000, 7'd2, 32'h0,
               4'b0001, 1'b0, 4'b1000, 1'b0, 32'h0};
    tv[5]  = '{4'b0100, 4'b0000, 7'd2, 32'h0,
               4'b0100, 1'b0, 4'b0001, 1'b0, 32'h0};
    tv[6]  = '{4'b0001, 4'b0000, 7'd3, 32'h0,
               4'b0001, 1'b0, 4'b0100, 1'b0, 32'h0};
    tv[7]  = '{4'b0100, 4'b0000, 7'd3, 32'h0,
               4'b0100, 1'b0, 4'b0001, 1'b0, 32'h0};
    tv[8]  = '{4'b0000, 4'b0000, 7'd3, 32'h0,
               4'b0000, 1'b0, 4'b0100, 1'b0, 32'h0};
    tv[9]  = '{4'b0101, 4'b0000, 7'd4, 32'h0,
               4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0};
    tv[10] = '{4'b0100, 4'b0000, 7'd4, 32'h0,
               4'b0100, 1'b0, 4'b0001, 1'b0, 32'h0};
    tv[11] = '{4'b0001, 4'b0001, 7'd7, 32'h1,
               4'b0001, 1'b1, 4'b0100, 1'b0, 32'h0};
    tv[12] = '{4'b0100, 4'b0100, 7'd7, 32'h2,
               4'b0100, 1'b1, 4'b0000, 1'b0, 32'h0};
    tv[13] = '{4'b0010, 4'b0000, 7'd7, 32'h0,
               4'b0010, 1'b0, 4'b0000, 1'b0, 32'h0};
    tv[14] = '{4'b0000, 4'b0000, 7'd7, 32'h0,
               4'b0000, 1'b0, 4'b0010, 1'b1, 32'h2};

    for (int i = 0; i < 128; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = 1'b0;
    end
    exp_rd    = '0;
    exp_rd_ok = 1'b0;
    model_reset();

    // reset: outputs forced low even with requests pending
    rst_n = 1'b0;
    drive(4'b1111, 4'b0000, 7'd0, 32'h0);
    #2;
    chk("reset_gnt", gnt, 0);
    chk("reset_ce", ram_ce0, 0);
    chk("reset_rvalid", rvalid, 0);
    drive(4'b0000, 4'b0000, 7'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].r, tv[i].w, tv[i].a, tv[i].d);
      @(negedge clk);
      chk($sformatf("tv%0d_gnt", i), gnt, tv[i].e_gnt);
      chk($sformatf("tv%0d_we0", i), ram_we0, tv[i].e_we0);
      chk($sformatf("tv%0d_rv", i), rvalid, tv[i].e_rv);
      if (tv[i].c_rd)
        chk($sformatf("tv%0d_rd", i), rdata, tv[i].e_rd);
      model_step();
      @(posedge clk);
      #1;
    end

    // reset while a read response is pending
    drive(4'b0010, 4'b0000, 7'd7, 32'h0);
    tick();
    chk("pre_rst_rvalid", rvalid, 4'b0010);
    chk("pre_rst_rdata", rdata, 32'h2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ce", ram_ce0, 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // all four hold reads: bursts of BM per requester
    req    = 4'b1111;
    req_we = 4'b0000;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(16 + i);
      req_d[i*DW +: DW]    = '0;
    end
    for (int k = 0; k < 12; k++) begin
      logic [N-1:0] eg, ev;
      eg = '0;
      eg[k/4] = 1'b1;
      ev = '0;
      if (k > 0) ev[(k-1)/4] = 1'b1;
      @(negedge clk);
      chk($sformatf("rr%0d_gnt", k), gnt, eg);
      chk($sformatf("rr%0d_rv", k), rvalid, ev);
      chk("rr_onehot", $countones(rvalid) <= 1, 1);
      model_step();
      @(posedge clk);
      #1;
    end
    drive(4'b0000, 4'b0000, 7'd0, 32'h0);
    tick();

    // sole requester 3: long bursts, never rotated out
    for (int k = 0; k < 10; k++) begin
      drive(4'b1000, 4'b1000, AW'(k), DW'(32'h100 + k));
      @(negedge clk);
      chk($sformatf("solo_w%0d_gnt", k), gnt, 4'b1000);
      model_step();
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 10; k++) begin
      drive(4'b1000, 4'b0000, AW'(k), 32'h0);
      @(negedge clk);
      chk($sformatf("solo_r%0d_gnt", k), gnt, 4'b1000);
      if (k > 0) begin
        chk($sformatf("solo_r%0d_rv", k), rvalid, 4'b1000);
        chk($sformatf("solo_r%0d_rd", k), rdata,
            DW'(32'h100 + k - 1));
      end
      model_step();
      @(posedge clk);
      #1;
    end
    drive(4'b0000, 4'b0000, 7'd0, 32'h0);
    @(negedge clk);
    chk("solo_last_rv", rvalid, 4'b1000);
    chk("solo_last_rd", rdata, 32'h109);
    model_step();
    @(posedge clk);
    #1;

    // randomized traffic; waiting requesters hold fields
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_g == i || !req[i]) begin
          req[i]    = ($urandom_range(0, 99) < 60);
          req_we[i] = ($urandom_range(0, 2) == 0);
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
          req_d[i*DW +: DW]    = $urandom;
        end
      end
      tick();
    end
    drive(4'b0000, 4'b0000, 7'd0, 32'h0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
